// File: rtl/icache_pkg.sv
// Shared instruction-cache types and geometry, used by the cache, the instruction memory and the refill controller.
package icache_pkg;

    localparam int LINE_WIDTH  = 128;
    localparam int OFFSET_BITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        FILL,
        RESUME,
        ERROR
    } refill_state_t;

endpackage

// File: rtl/icache_refill_controller_timeout_counter.sv
// Saturating 8-bit wait counter for the refill memory request.
// 'expired' is high in the enabled cycle that would make the count reach LIMIT.
module refill_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_reg;
    logic [7:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != 8'hFF)) begin
            count_next = count_reg + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = enable && !clear && (count_reg == 8'(LIMIT - 1));

endmodule

// File: rtl/icache_refill_controller.sv
// Instruction-cache line refill sequencer: stalls the PC on a miss, fetches the aligned line, writes it.
// Optional ICACHE_REFILL_STATS_EN adds miss_count and stall_cycle_count outputs.
module icache_refill_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = icache_pkg::LINE_WIDTH,
    parameter int OFFSET_BITS    = icache_pkg::OFFSET_BITS,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    input  logic                  cache_hit,
    input  logic                  branch_flush,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic                  mem_ready,
    input  logic [LINE_WIDTH-1:0] mem_data_line,
    output logic                  fill_enable,
    output logic [ADDR_WIDTH-1:0] fill_address,
    output logic [LINE_WIDTH-1:0] fill_data_line,
    output logic                  pc_stall,
    output logic                  refill_busy,
`ifdef ICACHE_REFILL_STATS_EN
    output logic [31:0]           miss_count,
    output logic [31:0]           stall_cycle_count,
`endif
    output logic                  timeout_error
);

    import icache_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

    refill_state_t state_reg;
    refill_state_t state_next;

    logic miss;
    logic start_refill;
    logic transfer;
    logic wait_expired;
    logic mem_req_reg;
    logic fill_enable_reg;
    logic timeout_error_reg;
    logic [ADDR_WIDTH-1:0] mem_address_reg;
    logic [ADDR_WIDTH-1:0] fill_address_reg;
    logic [LINE_WIDTH-1:0] fill_data_reg;

    // A redirect never aborts a refill; the in-flight line is filled as a harmless prefetch.
    logic unused_branch_flush;
    assign unused_branch_flush = branch_flush;

    assign miss         = fetch_valid & ~cache_hit;
    assign start_refill = (state_reg == IDLE) & miss;
    assign transfer     = (state_reg == REQUEST) & mem_ready;

    refill_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start_refill),
        .enable  ((state_reg == REQUEST) & ~mem_ready),
        .expired (wait_expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (miss) state_next = REQUEST;
            REQUEST: begin
                if (mem_ready) begin
                    state_next = FILL;
                end else if (wait_expired) begin
                    state_next = ERROR;
                end
            end
            FILL:    state_next = RESUME;
            RESUME:  state_next = IDLE;
            ERROR:   state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            mem_req_reg       <= 1'b0;
            mem_address_reg   <= '0;
            fill_enable_reg   <= 1'b0;
            fill_address_reg  <= '0;
            fill_data_reg     <= '0;
            timeout_error_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mem_req_reg     <= (state_next == REQUEST);
            fill_enable_reg <= transfer;
            if (start_refill) begin
                mem_address_reg <= fetch_address & LINE_MASK;
            end
            if (transfer) begin
                fill_address_reg <= mem_address_reg;
                fill_data_reg    <= mem_data_line;
            end
            if (state_next == ERROR) begin
                timeout_error_reg <= 1'b1;
            end
        end
    end

    // The miss cycle itself must already hold the PC, so the stall is combinational.
    assign pc_stall       = (state_reg != IDLE) | miss;
    assign refill_busy    = (state_reg != IDLE);
    assign mem_req        = mem_req_reg;
    assign mem_address    = mem_address_reg;
    assign fill_enable    = fill_enable_reg;
    assign fill_address   = fill_address_reg;
    assign fill_data_line = fill_data_reg;
    assign timeout_error  = timeout_error_reg;

`ifdef ICACHE_REFILL_STATS_EN
    logic [31:0] miss_count_reg;
    logic [31:0] stall_count_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            miss_count_reg  <= '0;
            stall_count_reg <= '0;
        end else begin
            if (start_refill) miss_count_reg <= miss_count_reg + 32'd1;
            if (pc_stall) stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign miss_count        = miss_count_reg;
    assign stall_cycle_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_icache_refill_controller.sv
// Scoreboard bench for icache_refill_controller: stimulus pushes expected requests, fills and
// stall-run lengths; a negedge monitor pops and compares whenever the DUT presents them.
module tb_icache_refill_controller;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          fetch_valid = 1'b0;
    logic [AW-1:0] fetch_address = '0;
    logic          cache_hit = 1'b0;
    logic          branch_flush = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_address;
    logic          mem_ready = 1'b0;
    logic [LW-1:0] mem_data_line = '0;
    logic          fill_enable;
    logic [AW-1:0] fill_address;
    logic [LW-1:0] fill_data_line;
    logic          pc_stall;
    logic          refill_busy;
    logic          timeout_error;
`ifdef ICACHE_REFILL_STATS_EN
    logic [31:0]   miss_count;
    logic [31:0]   stall_cycle_count;
`endif

    always #5 clock = ~clock;

    icache_refill_controller dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .fetch_valid       (fetch_valid),
        .fetch_address     (fetch_address),
        .cache_hit         (cache_hit),
        .branch_flush      (branch_flush),
        .mem_req           (mem_req),
        .mem_address       (mem_address),
        .mem_ready         (mem_ready),
        .mem_data_line     (mem_data_line),
        .fill_enable       (fill_enable),
        .fill_address      (fill_address),
        .fill_data_line    (fill_data_line),
        .pc_stall          (pc_stall),
        .refill_busy       (refill_busy),
`ifdef ICACHE_REFILL_STATS_EN
        .miss_count        (miss_count),
        .stall_cycle_count (stall_cycle_count),
`endif
        .timeout_error     (timeout_error)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            len;
    } req_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } fill_exp_t;

    req_exp_t  exp_req_q[$];
    fill_exp_t exp_fill_q[$];
    int        exp_stall_q[$];

    int checks = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Monitor: pops expectations as the DUT presents request runs, fill strobes and stall runs.
    int        req_run = 0;
    int        stall_run = 0;
    logic      prev_req = 1'b0;
    req_exp_t  req_e;
    fill_exp_t fill_e;
    int        stall_e;

    always @(negedge clock) begin
        if (!reset_n) begin
            if ((req_run > 0) && (exp_req_q.size() > 0)) begin
                req_e = exp_req_q.pop_front();
                $display("req aborted by reset addr=%h after %0d cycles", req_e.addr, req_run);
            end
            req_run   = 0;
            stall_run = 0;
        end else begin
            if (mem_req) begin
                req_run++;
                check("req_expected", 128'(exp_req_q.size() != 0), 128'(1));
                if (exp_req_q.size() != 0) begin
                    check("mem_address", 128'(mem_address), 128'(exp_req_q[0].addr));
                end
            end else if (req_run > 0) begin
                check("req_expected", 128'(exp_req_q.size() != 0), 128'(1));
                if (exp_req_q.size() != 0) begin
                    req_e = exp_req_q.pop_front();
                    $display("req addr=%h cycles=%0d", req_e.addr, req_run);
                    check("req_cycles", 128'(req_run), 128'(req_e.len));
                end
                req_run = 0;
            end
            if (fill_enable) begin
                check("fill_expected", 128'(exp_fill_q.size() != 0), 128'(1));
                check("fill_after_req", 128'(prev_req), 128'(1));
                if (exp_fill_q.size() != 0) begin
                    fill_e = exp_fill_q.pop_front();
                    $display("fill addr=%h data=%h", fill_address, fill_data_line);
                    check("fill_address", 128'(fill_address), 128'(fill_e.addr));
                    check("fill_data", fill_data_line, fill_e.data);
                end
            end
            if (pc_stall) begin
                stall_run++;
            end else if (stall_run > 0) begin
                check("stall_expected", 128'(exp_stall_q.size() != 0), 128'(1));
                if (exp_stall_q.size() != 0) begin
                    stall_e = exp_stall_q.pop_front();
                    $display("stall run cycles=%0d", stall_run);
                    check("stall_cycles", 128'(stall_run), 128'(stall_e));
                end
                stall_run = 0;
            end
        end
        prev_req = mem_req;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Miss at addr; memory answers in REQUEST cycle nwait; optional flush in REQUEST cycle flush_at.
    task automatic refill(input logic [AW-1:0] addr, input int nwait, input logic [LW-1:0] line,
                          input int flush_at, input logic [AW-1:0] target);
        logic [AW-1:0] la;
        la = addr & 32'hFFFF_FFF0;
        exp_req_q.push_back('{la, nwait});
        exp_fill_q.push_back('{la, line});
        exp_stall_q.push_back(nwait + 3);
        fetch_valid   = 1'b1;
        cache_hit     = 1'b0;
        fetch_address = addr;
        step();
        for (int i = 1; i <= nwait; i++) begin
            mem_ready     = (i == nwait);
            mem_data_line = (i == nwait) ? line : ~line;
            branch_flush  = (i == flush_at);
            if (i == flush_at) fetch_address = target;
            step();
        end
        // FILL cycle: a stray mem_ready with other data must be ignored.
        branch_flush  = 1'b0;
        cache_hit     = 1'b1;
        mem_ready     = 1'b1;
        mem_data_line = ~line;
        step();
        mem_ready = 1'b0;
        step();
        step();
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_mem_req", 128'(mem_req), 128'(0));
        check("rst_mem_address", 128'(mem_address), 128'(0));
        check("rst_fill_enable", 128'(fill_enable), 128'(0));
        check("rst_fill_address", 128'(fill_address), 128'(0));
        check("rst_fill_data", fill_data_line, 128'(0));
        check("rst_timeout_error", 128'(timeout_error), 128'(0));
        check("rst_pc_stall", 128'(pc_stall), 128'(0));
        check("rst_refill_busy", 128'(refill_busy), 128'(0));

        // Hit path
        fetch_valid   = 1'b1;
        cache_hit     = 1'b1;
        fetch_address = 32'h0000_0100;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clock);
            check("hit_pc_stall", 128'(pc_stall), 128'(0));
            check("hit_mem_req", 128'(mem_req), 128'(0));
        end
        step();

        // Miss at 0x24 answered in the third REQUEST cycle
        refill(32'h0000_0024, 3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, '0);
        // Ready in the first REQUEST cycle, unaligned high address
        refill(32'h1234_567F, 1, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 0, '0);
        // Redirect mid-REQUEST, then the branch target misses and is serviced
        refill(32'h0000_0408, 3, 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0, 2, 32'h0000_0804);
        refill(32'h0000_0804, 2, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, '0);

        // Memory never answers
        exp_req_q.push_back('{32'h0000_1000, 255});
        fetch_valid   = 1'b1;
        cache_hit     = 1'b0;
        fetch_address = 32'h0000_100C;
        step();
        repeat (254) step();
        @(negedge clock);
        check("to_last_req_error", 128'(timeout_error), 128'(0));
        check("to_last_req_mem_req", 128'(mem_req), 128'(1));
        step();
        @(negedge clock);
        check("to_error", 128'(timeout_error), 128'(1));
        check("to_mem_req", 128'(mem_req), 128'(0));
        check("to_pc_stall", 128'(pc_stall), 128'(1));
        mem_ready     = 1'b1;
        mem_data_line = 128'hFFFF;
        repeat (3) step();
        @(negedge clock);
        check("to_sticky", 128'(timeout_error), 128'(1));
        check("to_busy", 128'(refill_busy), 128'(1));
        step();
        mem_ready   = 1'b0;
        reset_n     = 1'b0;
        fetch_valid = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clock);
        check("to_rst_error", 128'(timeout_error), 128'(0));
        check("to_rst_pc_stall", 128'(pc_stall), 128'(0));
        check("to_rst_mem_address", 128'(mem_address), 128'(0));

        // Reset during REQUEST aborts without a fill
        step();
        exp_req_q.push_back('{32'h0000_2000, 0});
        fetch_valid   = 1'b1;
        cache_hit     = 1'b0;
        fetch_address = 32'h0000_2008;
        step();
        cache_hit = 1'b1;
        step();
        reset_n       = 1'b0;
        mem_ready     = 1'b1;
        mem_data_line = 128'hBAD;
        step();
        reset_n     = 1'b1;
        mem_ready   = 1'b0;
        fetch_valid = 1'b0;
        @(negedge clock);
        check("abort_mem_req", 128'(mem_req), 128'(0));
        check("abort_busy", 128'(refill_busy), 128'(0));
        check("abort_fill_enable", 128'(fill_enable), 128'(0));
        check("abort_fill_data", fill_data_line, 128'(0));
        repeat (2) step();

        // Two misses after reset
        refill(32'h0000_3004, 1, 128'h0000_0000_0000_0000_0000_0000_0000_0042, 0, '0);
        refill(32'h0000_3018, 2, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 0, '0);
        @(negedge clock);
`ifdef ICACHE_REFILL_STATS_EN
        check("stats_miss_count", 128'(miss_count), 128'(2));
        check("stats_stall_cycles", 128'(stall_cycle_count), 128'(9));
`endif
        fetch_valid = 1'b0;
        repeat (3) step();
        @(negedge clock);
        check("req_q_empty", 128'(exp_req_q.size()), 128'(0));
        check("fill_q_empty", 128'(exp_fill_q.size()), 128'(0));
        check("stall_q_empty", 128'(exp_stall_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
